// File: rtl/jk_bank_ctrl_if.sv
// Command channel for the JK bank sequencer: valid/ready handshake plus op payload.
interface jk_cmd_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [STEPW-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_steps,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  cmd_steps,
                  output cmd_ready);
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer for an external bank of JK flip-flops: load/clear/count commands,
// with a readback check of the bank against a shadow copy after every drive.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  jk_cmd_if.slave          cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             drive_en;
  logic [1:0]       drive_op;
  logic [WIDTH-1:0] drive_data;

  // Toggle mask for a binary count: bit i flips when all lower bits are 1 (up) or 0 (down).
  function automatic logic [WIDTH-1:0] count_mask(input logic [WIDTH-1:0] s, input logic down);
    logic run;
    count_mask = '0;
    run        = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_mask[i] = run;
      run           = run & (down ? ~s[i] : s[i]);
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    steps_d    = steps_q;
    shadow_d   = shadow_q;
    err_d      = err_q;
    drive_en   = 1'b0;
    drive_op   = op_q;
    drive_data = data_q;
    j_d        = '0;
    k_d        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          data_d  = cmd.cmd_data;
          steps_d = cmd.cmd_steps;
          err_d   = 1'b0;
          if (cmd.cmd_op[1] && (cmd.cmd_steps == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_DRIVE;
            drive_en   = 1'b1;
            drive_op   = cmd.cmd_op;
            drive_data = cmd.cmd_data;
          end
        end
      end
      S_DRIVE: begin
        // Mirror the bank's JK capture on the same edge it happens.
        shadow_d = (j_q & ~shadow_q) | (~k_q & shadow_q);
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (q_in != shadow_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!op_q[1]) begin
          state_d = S_DONE;
        end else begin
          steps_d = steps_q - STEPW'(1);
          if (steps_q != STEPW'(1)) begin
            state_d  = S_DRIVE;
            drive_en = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (drive_en) begin
      unique case (drive_op)
        OP_LOAD:  begin j_d = drive_data; k_d = ~drive_data; end
        OP_CLEAR: begin j_d = '0;         k_d = '1;          end
        OP_UP:    begin j_d = count_mask(shadow_q, 1'b0); k_d = j_d; end
        OP_DOWN:  begin j_d = count_mask(shadow_q, 1'b1); k_d = j_d; end
        default:  begin j_d = '0;         k_d = '0;          end
      endcase
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      steps_q  <= '0;
      shadow_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      steps_q  <= steps_d;
      shadow_q <= shadow_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign j_out         = j_q;
  assign k_out         = k_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
